// File: rtl/adt7420_reader.sv
// adt7420_reader
// Periodic I2C read of the ADT7420 13-bit temperature register. It uses the
// 200 kHz scl_ref square wave as the bit-timing reference and drives
// open-drain SCL/SDA through a top-level tristate.
//
// State table:
//   IDLE   | bus released, waiting for an scl_ref rising tick to issue START
//   START  | SDA pulled low with SCL high; lowers SCL on the next falling tick
//   ADDR   | shifts out the read address byte {DEV_ADDR,1}, MSB first
//   ACK_A  | samples the slave's address acknowledge
//   RD_MSB | shifts in the temperature MSB
//   ACK_M  | master acknowledges the MSB (drives 0)
//   RD_LSB | shifts in the temperature LSB
//   NACK_M | master releases SDA to end the read
//   STOP   | STOP condition; publishes the reading if the address was ACKed
//   WAIT   | counts POLL_TICKS rising ticks before the next transaction
//
// Ports:
//   clock_in   : 100 MHz system clock
//   reset_n    : asynchronous active-low reset
//   scl_ref    : 200 kHz bit-timing reference, synchronous to clock_in
//   sda_in     : sampled SDA pin level
//   scl_out    : SCL level (1 = released, 0 = pulled low)
//   sda_oe     : 1 = pull SDA low, 0 = release
//   temp_raw   : last good reading {MSB, LSB[7:3]}, 1/16 degC per LSB
//   temp_valid : one-cycle pulse when temp_raw updates
//   ack_err    : sticky address-NACK flag, cleared by the next good read
//   busy       : high from START through STOP
module adt7420_reader #(
  parameter logic [6:0]  DEV_ADDR   = 7'h4B,
  parameter int          SDA_HOLD   = 25,
  parameter logic [15:0] POLL_TICKS = 16'd48000
) (
  input  logic        clock_in,
  input  logic        reset_n,
  input  logic        scl_ref,
  input  logic        sda_in,
  output logic        scl_out,
  output logic        sda_oe,
  output logic [12:0] temp_raw,
  output logic        temp_valid,
  output logic        ack_err,
  output logic        busy
);

  localparam logic [7:0] ADDR_BYTE = {DEV_ADDR, 1'b1};
  // Loading SDA_HOLD+1 and acting when the count is 1 places the SDA change
  // exactly SDA_HOLD+1 cycles after SCL is pulled low.
  localparam logic [7:0] HOLD_LOAD = 8'(SDA_HOLD + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_ADDR, S_ACK_A, S_RD_MSB,
    S_ACK_M, S_RD_LSB, S_NACK_M, S_STOP, S_WAIT
  } state_t;

  state_t      state;
  logic        scl_ref_d;
  logic [7:0]  hold_cnt;
  logic [2:0]  bit_cnt;
  logic [15:0] poll_cnt;
  logic [7:0]  shreg;
  logic [7:0]  msb;
  logic        acked;

  logic rise_tick, fall_tick, hold_due, in_slot, slot_drive;

  assign rise_tick = scl_ref & ~scl_ref_d;
  assign fall_tick = ~scl_ref & scl_ref_d;
  assign hold_due  = (hold_cnt == 8'd1);
  assign in_slot   = (state == S_ADDR)   || (state == S_ACK_A) ||
                     (state == S_RD_MSB) || (state == S_ACK_M) ||
                     (state == S_RD_LSB) || (state == S_NACK_M);

  // Level the master puts on SDA (as a pull-low enable) during a bit slot.
  always_comb begin
    slot_drive = 1'b0;
    case (state)
      S_ADDR:  slot_drive = ~ADDR_BYTE[bit_cnt];
      S_ACK_M: slot_drive = 1'b1;
      default: slot_drive = 1'b0;
    endcase
  end

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      scl_ref_d  <= 1'b0;
      scl_out    <= 1'b1;
      sda_oe     <= 1'b0;
      temp_raw   <= '0;
      temp_valid <= 1'b0;
      ack_err    <= 1'b0;
      busy       <= 1'b0;
      hold_cnt   <= '0;
      bit_cnt    <= '0;
      poll_cnt   <= '0;
      shreg      <= '0;
      msb        <= '0;
      acked      <= 1'b0;
    end else begin
      scl_ref_d  <= scl_ref;
      temp_valid <= 1'b0;
      if (hold_cnt != 8'd0) hold_cnt <= hold_cnt - 8'd1;

      // Shared bit-slot timing: SDA update after the hold, SCL high on the
      // rising tick, SCL low (and hold restart) on the falling tick.
      if (in_slot) begin
        if (hold_due)  sda_oe  <= slot_drive;
        if (rise_tick) scl_out <= 1'b1;
        if (fall_tick) begin
          scl_out  <= 1'b0;
          hold_cnt <= HOLD_LOAD;
        end
      end

      case (state)
        S_IDLE: if (rise_tick) begin
          sda_oe <= 1'b1;
          busy   <= 1'b1;
          acked  <= 1'b0;
          state  <= S_START;
        end
        S_START: if (fall_tick) begin
          scl_out  <= 1'b0;
          bit_cnt  <= 3'd7;
          hold_cnt <= HOLD_LOAD;
          state    <= S_ADDR;
        end
        S_ADDR: if (fall_tick) begin
          if (bit_cnt == 3'd0) state <= S_ACK_A;
          else bit_cnt <= bit_cnt - 3'd1;
        end
        S_ACK_A: if (fall_tick) begin
          if (sda_in) begin
            ack_err <= 1'b1;
            state   <= S_STOP;
          end else begin
            acked   <= 1'b1;
            bit_cnt <= 3'd7;
            state   <= S_RD_MSB;
          end
        end
        S_RD_MSB: if (fall_tick) begin
          shreg <= {shreg[6:0], sda_in};
          if (bit_cnt == 3'd0) begin
            msb   <= {shreg[6:0], sda_in};
            state <= S_ACK_M;
          end else bit_cnt <= bit_cnt - 3'd1;
        end
        S_ACK_M: if (fall_tick) begin
          bit_cnt <= 3'd7;
          state   <= S_RD_LSB;
        end
        S_RD_LSB: if (fall_tick) begin
          shreg <= {shreg[6:0], sda_in};
          if (bit_cnt == 3'd0) state <= S_NACK_M;
          else bit_cnt <= bit_cnt - 3'd1;
        end
        S_NACK_M: if (fall_tick) state <= S_STOP;
        S_STOP: begin
          if (hold_due)  sda_oe  <= 1'b1;
          if (rise_tick) scl_out <= 1'b1;
          if (fall_tick) begin
            // SDA released while SCL is high: the STOP condition.
            sda_oe   <= 1'b0;
            busy     <= 1'b0;
            poll_cnt <= '0;
            state    <= S_WAIT;
            if (acked) begin
              temp_raw   <= {msb, shreg[7:3]};
              temp_valid <= 1'b1;
              ack_err    <= 1'b0;
            end
          end
        end
        S_WAIT: if (rise_tick) begin
          if (poll_cnt == POLL_TICKS - 16'd1) state <= S_IDLE;
          else poll_cnt <= poll_cnt + 16'd1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adt7420_reader.sv
// Testbench for adt7420_reader: table of slave responses with expected
// readings, plus hand-written reset/latency sequences. A small slave model
// drives SDA, and a monitor checks address bits, ACK/NACK driving and the
// SDA hold time of every SDA change while SCL is low.
module tb_adt7420_reader;

  localparam int          HALF     = 60;  // scl_ref half period in clock_in cycles
  localparam int          SDA_HOLD = 25;
  localparam logic [15:0] POLL     = 16'd4;

  logic        clock_in, reset_n, scl_ref, sda_in;
  logic        scl_out, sda_oe, temp_valid, ack_err, busy;
  logic [12:0] temp_raw;
  logic        slave_low;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  adt7420_reader #(.DEV_ADDR(7'h4B), .SDA_HOLD(SDA_HOLD), .POLL_TICKS(POLL)) dut (
    .clock_in(clock_in), .reset_n(reset_n), .scl_ref(scl_ref), .sda_in(sda_in),
    .scl_out(scl_out), .sda_oe(sda_oe), .temp_raw(temp_raw),
    .temp_valid(temp_valid), .ack_err(ack_err), .busy(busy)
  );

  // Open-drain bus: low if either side pulls.
  assign sda_in = ~(sda_oe | slave_low);

  initial clock_in = 1'b0;
  always #5 clock_in = ~clock_in;
  always @(posedge clock_in) cyc <= cyc + 1;

  initial begin
    scl_ref = 1'b0;
    forever begin
      repeat (HALF) @(posedge clock_in);
      #1 scl_ref = ~scl_ref;
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1);
  end

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Slave configuration and monitor state
  logic       cfg_ack;
  logic [7:0] cfg_msb, cfg_lsb;
  int   slot = -1;
  logic scl_prev = 1'b1, busy_prev = 1'b0, ref_prev = 1'b0, oe_prev = 1'b0;
  int   fall_cyc = 0, rise_cnt = 0, gap_rises = 0, frame_rises = 0, frame_rises_last = 0;
  int   valid_cycles = 0;
  logic [7:0] addr_bits;
  logic ackm_oe, nackm_oe;

  initial slave_low = 1'b0;

  always @(negedge clock_in) begin
    if (!reset_n) begin
      slot      = -1;
      slave_low = 1'b0;
      rise_cnt  = 0;
    end else begin
      if (busy && !busy_prev) begin
        gap_rises    = rise_cnt;
        frame_rises  = 0;
        valid_cycles = 0;
        addr_bits    = 8'h00;
        ackm_oe      = 1'b0;
        nackm_oe     = 1'b1;
        slot         = -1;
      end
      if (!busy && busy_prev) begin
        frame_rises_last = frame_rises;
        rise_cnt  = 0;
        slave_low = 1'b0;
      end
      if (scl_ref && !ref_prev) begin
        if (busy) frame_rises++;
        else rise_cnt++;
      end
      if (temp_valid) valid_cycles++;
      if (busy && scl_prev && !scl_out) begin
        int idx;
        slot++;
        fall_cyc  = cyc;
        slave_low = 1'b0;
        if (cfg_ack) begin
          if (slot == 8) slave_low = 1'b1;
          else if (slot >= 9 && slot <= 16) begin
            idx = 16 - slot;
            slave_low = ~cfg_msb[idx[2:0]];
          end else if (slot >= 18 && slot <= 25) begin
            idx = 25 - slot;
            slave_low = ~cfg_lsb[idx[2:0]];
          end
        end
      end
      if (busy && !scl_prev && scl_out) begin
        if (slot >= 0 && slot <= 7) begin
          int idx;
          idx = 7 - slot;
          addr_bits[idx[2:0]] = ~sda_oe;
        end
        if (slot == 17) ackm_oe = sda_oe;
        if (slot == 26) nackm_oe = sda_oe;
      end
      if (busy && !scl_out && !scl_prev && (sda_oe != oe_prev))
        check("sda_hold", cyc - fall_cyc, SDA_HOLD + 1);
    end
    scl_prev  = scl_out;
    busy_prev = busy;
    ref_prev  = scl_ref;
    oe_prev   = sda_oe;
  end

  task automatic wait_busy(input logic lvl, input int budget, input string name);
    int n = 0;
    while (busy !== lvl && n < budget) begin
      @(negedge clock_in);
      n++;
    end
    check(name, int'(busy), int'(lvl));
  endtask

  typedef struct {
    logic        ack;
    logic [7:0]  msb;
    logic [7:0]  lsb;
    logic [12:0] temp;
    int          valid;
    logic        err;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int c1, n;
    vecs[0] = '{1'b1, 8'h0C, 8'h80, 13'h0190, 1, 1'b0};
    vecs[1] = '{1'b1, 8'hE7, 8'h07, 13'h1CE0, 1, 1'b0};
    vecs[2] = '{1'b0, 8'h55, 8'h55, 13'h1CE0, 0, 1'b1};
    vecs[3] = '{1'b1, 8'h01, 8'hF8, 13'h003F, 1, 1'b0};
    vecs[4] = '{1'b1, 8'h7F, 8'hF0, 13'h0FFE, 1, 1'b0};

    cfg_ack = 1'b1; cfg_msb = 8'h0C; cfg_lsb = 8'h80;
    reset_n = 1'b0;
    repeat (5) @(negedge clock_in);
    check("rst_scl_out", int'(scl_out), 1);
    check("rst_sda_oe", int'(sda_oe), 0);
    check("rst_temp_raw", int'(temp_raw), 0);
    check("rst_temp_valid", int'(temp_valid), 0);
    check("rst_ack_err", int'(ack_err), 0);
    check("rst_busy", int'(busy), 0);

    // Release just after scl_ref falls, then measure START / first SCL fall latency.
    n = 0; while (scl_ref !== 1'b1 && n < 500) begin @(negedge clock_in); n++; end
    n = 0; while (scl_ref !== 1'b0 && n < 500) begin @(negedge clock_in); n++; end
    reset_n = 1'b1;
    n = 0; while (scl_ref !== 1'b1 && n < 500) begin @(negedge clock_in); n++; end
    c1 = cyc;
    n = 0; while (sda_oe !== 1'b1 && n < 500) begin @(negedge clock_in); n++; end
    check("start_latency", cyc - c1, 1);
    check("start_busy", int'(busy), 1);
    n = 0; while (scl_ref !== 1'b0 && n < 500) begin @(negedge clock_in); n++; end
    c1 = cyc;
    n = 0; while (scl_out !== 1'b0 && n < 500) begin @(negedge clock_in); n++; end
    check("scl_fall_latency", cyc - c1, 1);

    // Reset in the middle of RD_MSB.
    n = 0; while (slot != 12 && n < 5000) begin @(negedge clock_in); n++; end
    check("reach_rd_msb", slot, 12);
    repeat (10) @(negedge clock_in);
    check("mid_scl_low", int'(scl_out), 0);
    reset_n = 1'b0;
    #1;
    check("mid_rst_scl", int'(scl_out), 1);
    check("mid_rst_sda", int'(sda_oe), 0);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_temp", int'(temp_raw), 0);
    repeat (5) @(negedge clock_in);
    n = 0; while (scl_ref !== 1'b0 && n < 500) begin @(negedge clock_in); n++; end
    reset_n = 1'b1;
    wait_busy(1'b1, 500, "restart_busy");
    @(posedge clock_in);
    check("restart_gap", gap_rises, 1);

    for (int i = 0; i < 5; i++) begin
      cfg_ack = vecs[i].ack; cfg_msb = vecs[i].msb; cfg_lsb = vecs[i].lsb;
      if (i > 0) begin
        wait_busy(1'b1, 2000, "frame_start");
        @(posedge clock_in);
        check("poll_gap", gap_rises, int'(POLL) + 1);
      end
      wait_busy(1'b0, 5000, "frame_end");
      repeat (3) @(negedge clock_in);
      check($sformatf("v%0d_temp_raw", i), int'(temp_raw), int'(vecs[i].temp));
      check($sformatf("v%0d_valid_cycles", i), valid_cycles, vecs[i].valid);
      check($sformatf("v%0d_ack_err", i), int'(ack_err), int'(vecs[i].err));
      check($sformatf("v%0d_frame_rises", i), frame_rises_last, vecs[i].ack ? 28 : 10);
      check($sformatf("v%0d_addr_bits", i), int'(addr_bits), 8'h97);
      if (vecs[i].ack) begin
        check($sformatf("v%0d_ack_m_drive", i), int'(ackm_oe), 1);
        check($sformatf("v%0d_nack_m_release", i), int'(nackm_oe), 0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/adt7420_reader.md
# adt7420_reader

I2C master that periodically reads the 13-bit temperature from the ADT7420 sensor. It sits directly downstream of the 200 kHz divider, consumes its square wave as a bit-timing reference, and drives the open-drain SCL/SDA pins through a top-level tristate. It presents the latest reading to the display logic with a one-cycle valid strobe.

## Interface
- DEV_ADDR, 7'h4B: 7-bit sensor bus address; the read address byte is {DEV_ADDR,1'b1} = 8'h97.
- SDA_HOLD, 25: clock_in cycles from an SCL falling tick to any SDA change; must be less than 250.
- POLL_TICKS, 16'd48000: scl_ref rising ticks spent in WAIT between transactions.
- clock_in  input  1  100 MHz system clock; the only clock.
- reset_n  input  1  asynchronous, active-low reset.
- scl_ref  input  1  200 kHz square wave from the divider, synchronous to clock_in.
- sda_in  input  1  sampled SDA pin level.
- scl_out  output  1  SCL level; 1 = released, 0 = pulled low.
- sda_oe  output  1  1 = pull SDA low, 0 = release.
- temp_raw  output  13  last good reading, {MSB[7:0], LSB[7:3]}, two's complement, 1/16 °C per LSB.
- temp_valid  output  1  one-cycle pulse when temp_raw updates.
- ack_err  output  1  sticky flag for an address NACK; cleared by the next good read.
- busy  output  1  high from START through STOP.

## Operation
- Edge detect: register scl_ref_d.
  - rise_tick = scl_ref & ~scl_ref_d.
  - fall_tick = ~scl_ref & scl_ref_d.
- States: IDLE, START, ADDR, ACK_A, RD_MSB, ACK_M, RD_LSB, NACK_M, STOP, WAIT.
- IDLE:
  - SCL and SDA are released.
  - On rise_tick: set sda_oe=1 (START condition), set busy=1, go to START.
- START: on fall_tick set scl_out=0, bit counter=7, go to ADDR.
- Generic bit slot:
  - SDA_HOLD cycles after the fall_tick that lowered SCL, sda_oe takes the bit's value (sda_oe = ~bit; released for read bits).
  - Next rise_tick: scl_out=1.
  - Next fall_tick: sample sda_in into the shift/ack register, scl_out=0, advance.
- ADDR: shift 8'h97 out MSB-first; go to ACK_A.
- ACK_A:
  - SDA released.
  - Sample 0: go to RD_MSB.
  - Sample 1: set ack_err=1, go to STOP.
- RD_MSB: SDA released, 8 bits shifted in MSB-first; then ACK_M (master drives 0).
- RD_LSB: 8 bits shifted in; then NACK_M (master releases SDA, so the bus reads 1).
- STOP:
  - SDA_HOLD cycles after the fall_tick: sda_oe=1.
  - Next rise_tick: scl_out=1.
  - Next fall_tick: sda_oe=0 (SDA rises while SCL is high).
  - Same cycle: busy=0. If the address was ACKed, load temp_raw, pulse temp_valid, clear ack_err.
  - Go to WAIT, poll counter=0.
- WAIT:
  - Counter increments on each rise_tick.
  - On the rise_tick where the count reaches POLL_TICKS-1, return to IDLE.
  - The START issues on the following rise_tick.
- No pointer write is performed; the sensor's power-on pointer (0x00) is relied on.
- No slave clock-stretching support; SCL is never sampled.

## Timing
- Reset (asynchronous, immediate): state=IDLE, scl_out=1, sda_oe=0, temp_raw=0, temp_valid=0, ack_err=0, busy=0, counters=0, scl_ref_d=0.
- Ticks are registered, so all SCL transitions lag the scl_ref edges by 1 clock_in cycle.
- SCL is 200 kHz with 50% duty: 250 cycles high, 250 cycles low.
- Frame length: START + 9 + 9 + 9 bits + STOP = 29 scl_ref periods = 145 µs.
- NACK frame: START + 9 bits + STOP = 11 periods.
- Read bits are sampled at the SCL falling tick, 250 cycles after SCL rose.
- SDA never changes while scl_out=1, except for START and STOP.
- Reset asserted mid-frame releases the bus at once and sends no STOP. After release, the next START occurs on the first rise_tick.
- scl_ref held constant: the FSM freezes with outputs unchanged.

## Test plan
- Reset, then release: scl_out=1, sda_oe=0, all outputs 0. sda_oe rises 1 cycle after the first scl_ref rising edge, and scl_out falls 1 cycle after the next falling edge.
- Slave ACKs and returns MSB=0x0C, LSB=0x80: SDA bits at SCL rise read 1,0,0,1,0,1,1,1. temp_raw=13'h0190 (25.0 °C), temp_valid high for exactly 1 cycle, busy low after STOP.
- Slave returns MSB=0xE7, LSB=0x07: temp_raw=13'h1CE0, and LSB bits [2:0] are ignored.
- Address NACK:
  - ack_err=1, no temp_valid, STOP after 11 periods.
  - Next START occurs POLL_TICKS+1 rise_ticks later.
  - A good read on that retry clears ack_err.
- SDA hold check: every SDA change while SCL is low occurs exactly SDA_HOLD+1 cycles after scl_out falls. Master drives 0 in ACK_M and releases SDA in NACK_M.
- Assert reset_n=0 mid-RD_MSB: scl_out=1 and sda_oe=0 in the same cycle, temp_raw is unchanged at 0, and a fresh START follows release.
